// File: rtl/spi_chan_arbiter_pkg.sv
// rtl/spi_chan_arbiter_pkg.sv - state encodings and word magics for the SPI channel arbiter
package spi_chan_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_HDR  = 3'd2,
        S_LOAD = 3'd3,
        S_CAPT = 3'd4,
        S_SEND = 3'd5,
`ifdef SPI_ARB_TRAILER_EN
        S_TRL  = 3'd6,
`endif
        S_DONE = 3'd7
    } state_e;

    localparam logic [3:0] HDR_MAGIC = 4'hA;
    localparam logic [3:0] NULL_ID   = 4'hF;
    localparam logic [3:0] TRL_MAGIC = 4'h5;

endpackage

// File: rtl/spi_chan_arbiter_if.sv
// rtl/spi_chan_arbiter_if.sv - command, channel FIFO and transmit signals of the channel arbiter
interface spi_chan_arbiter_if #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int PKT_W = 8
);
    logic              fifo_cmd;
    logic              word_done;
    logic [PKT_W-1:0]  pkt_len;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_rd;
    logic [DW-1:0]     tx_data;
    logic              tx_valid;
    logic              busy;
    logic [3:0]        grant_id;

    modport master (
        output fifo_cmd, word_done, pkt_len, ch_ready, ch_data,
        input  ch_rd, tx_data, tx_valid, busy, grant_id
    );

    modport slave (
        input  fifo_cmd, word_done, pkt_len, ch_ready, ch_data,
        output ch_rd, tx_data, tx_valid, busy, grant_id
    );
endinterface

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker: first requester after ptr, wrapping
module spi_rr_pick #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req,
    input  logic [3:0]     ptr,
    output logic [NCH-1:0] gnt,
    output logic [3:0]     gnt_id,
    output logic           any
);

    int idx;

    always_comb begin
        gnt    = '0;
        gnt_id = 4'd0;
        any    = 1'b0;
        idx    = 0;
        // Offset NCH lands back on ptr itself, so the last owner wins only if alone.
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = 4'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_chan_arbiter.sv
// rtl/spi_chan_arbiter.sv - round-robin share of the SPI FIFO readout path between channel FIFOs
// Optional checksum trailer word when SPI_ARB_TRAILER_EN is defined.
module spi_chan_arbiter
    import spi_chan_arbiter_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int PKT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_chan_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic [PKT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       gid_q, gid_d;
    logic [NCH-1:0]   gnt_oh_q, gnt_oh_d;
    logic [DW-1:0]    tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic [NCH-1:0]   ch_rd_q, ch_rd_d;
`ifdef SPI_ARB_TRAILER_EN
    logic [DW-5:0]    xor_q, xor_d;
`endif

    logic [NCH-1:0]   pick_gnt;
    logic [3:0]       pick_id;
    logic             pick_any;
    logic [DW-1:0]    data_sel;

    function automatic logic [DW-1:0] make_hdr(input logic [3:0] id, input logic [PKT_W-1:0] len);
        logic [DW-1:0] h;
        h                = '0;
        h[DW-1 -: 4]     = HDR_MAGIC;
        h[DW-5 -: 4]     = id;
        h[DW-9 -: PKT_W] = len;
        return h;
    endfunction

`ifdef SPI_ARB_TRAILER_EN
    function automatic logic [DW-1:0] make_trl(input logic [DW-5:0] x);
        return {TRL_MAGIC, x};
    endfunction
`endif

    spi_rr_pick #(.NCH(NCH)) u_pick (
        .req    (bus.ch_ready),
        .ptr    (ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_oh_q[i]) data_sel = bus.ch_data[i*DW +: DW];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        gnt_oh_d  = gnt_oh_q;
        tx_data_d = tx_data_q;
`ifdef SPI_ARB_TRAILER_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.fifo_cmd) state_d = S_ARB;
            end
            S_ARB: begin
                // A null grant keeps the previous owner and pointer; cnt 0 skips all reads.
                if (pick_any) begin
                    gid_d     = pick_id;
                    gnt_oh_d  = pick_gnt;
                    ptr_d     = pick_id;
                    cnt_d     = bus.pkt_len;
                    tx_data_d = make_hdr(pick_id, bus.pkt_len);
                end else begin
                    gnt_oh_d  = '0;
                    cnt_d     = '0;
                    tx_data_d = make_hdr(NULL_ID, '0);
                end
`ifdef SPI_ARB_TRAILER_EN
                xor_d = '0;
`endif
                state_d = S_HDR;
            end
            S_HDR: begin
                if (bus.word_done) begin
                    if (cnt_q != '0) begin
                        state_d = S_LOAD;
                    end else begin
`ifdef SPI_ARB_TRAILER_EN
                        state_d   = S_TRL;
                        tx_data_d = make_trl(xor_q);
`else
                        state_d   = S_DONE;
`endif
                    end
                end
            end
            S_LOAD: state_d = S_CAPT;
            S_CAPT: begin
                tx_data_d = data_sel;
`ifdef SPI_ARB_TRAILER_EN
                xor_d     = xor_q ^ data_sel[DW-5:0];
`endif
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (bus.word_done) begin
                    cnt_d = (cnt_q != '0) ? cnt_q - PKT_W'(1) : cnt_q;
                    if (cnt_q <= PKT_W'(1)) begin
`ifdef SPI_ARB_TRAILER_EN
                        state_d   = S_TRL;
                        tx_data_d = make_trl(xor_q);
`else
                        state_d   = S_DONE;
`endif
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
`ifdef SPI_ARB_TRAILER_EN
            S_TRL: begin
                if (bus.word_done) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered images of the next state so they align with state_q.
        tx_valid_d = (state_d == S_HDR) || (state_d == S_SEND)
`ifdef SPI_ARB_TRAILER_EN
                     || (state_d == S_TRL)
`endif
                     ;
        busy_d  = (state_d != S_IDLE);
        ch_rd_d = (state_d == S_LOAD) ? gnt_oh_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= 4'(NCH - 1);
            gid_q      <= 4'd0;
            gnt_oh_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ch_rd_q    <= '0;
`ifdef SPI_ARB_TRAILER_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            gnt_oh_q   <= gnt_oh_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            ch_rd_q    <= ch_rd_d;
`ifdef SPI_ARB_TRAILER_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign bus.ch_rd    = ch_rd_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_spi_chan_arbiter.sv
// tb/tb_spi_chan_arbiter.sv - scoreboard bench for spi_chan_arbiter (trailer cases with SPI_ARB_TRAILER_EN)
module tb_spi_chan_arbiter;

`ifdef SPI_ARB_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_chan_arbiter_if #(.NCH(4), .DW(16), .PKT_W(8)) bus_if ();

    spi_chan_arbiter #(.NCH(4), .DW(16), .PKT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [15:0] fifo_q[4][$];
    logic [15:0] pdata[$];

    int busy_total = 0;
    int rd_cnt[4]  = '{0, 0, 0, 0};
    int rd_multi   = 0;
    logic [3:0] prev_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Channel FIFO model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rst) begin
            bus_if.ch_data <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus_if.ch_rd[i] && fifo_q[i].size() > 0)
                    bus_if.ch_data[i*16 +: 16] <= fifo_q[i].pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (bus_if.busy) busy_total++;
        for (int i = 0; i < 4; i++) if (bus_if.ch_rd[i]) rd_cnt[i]++;
        if ((bus_if.ch_rd & prev_rd) != 4'b0) rd_multi++;
        prev_rd = bus_if.ch_rd;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) fifo_q[i].delete();
        rst = 1'b0;
    endtask

    // g < 0 means no channel ready: null header.
    task automatic queue_pkt(input int g, input int len);
        logic [15:0] x;
        x = '0;
        if (g < 0) sb.push_back(16'hAF00);
        else       sb.push_back({4'hA, 4'(g), 8'(len)});
        if (g >= 0) begin
            foreach (pdata[k]) begin
                fifo_q[g].push_back(pdata[k]);
                sb.push_back(pdata[k]);
                x = x ^ pdata[k];
            end
        end
        if (TRL != 0) sb.push_back({4'h5, x[11:0]});
    endtask

    task automatic drain(input int cmd_at, input int abort_at);
        int idx;
        int t;
        logic [15:0] exp;
        idx = 0;
        while (sb.size() > 0) begin
            t = 0;
            while (!bus_if.tx_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) begin
                check("tx_timeout", 32'd0, 32'd1);
                sb.delete();
                return;
            end
            exp = sb.pop_front();
            check("tx_data", 32'(bus_if.tx_data), 32'(exp));
            if (idx == abort_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
                check("rst_busy",     32'(bus_if.busy),     32'd0);
                check("rst_ch_rd",    32'(bus_if.ch_rd),    32'd0);
                check("rst_tx_data",  32'(bus_if.tx_data),  32'd0);
                check("rst_grant_id", 32'(bus_if.grant_id), 32'd0);
                sb.delete();
                return;
            end
            if (idx == cmd_at) bus_if.fifo_cmd = 1'b1;
            @(negedge clk);
            bus_if.fifo_cmd  = 1'b0;
            bus_if.word_done = 1'b1;
            @(negedge clk);
            bus_if.word_done = 1'b0;
            check("valid_drop", 32'(bus_if.tx_valid), 32'd0);
            idx++;
        end
    endtask

    task automatic start_pkt();
        @(negedge clk);
        bus_if.fifo_cmd = 1'b1;
        @(negedge clk);
        bus_if.fifo_cmd = 1'b0;
        check("arb_busy",  32'(bus_if.busy),     32'd1);
        check("arb_valid", 32'(bus_if.tx_valid), 32'd0);
        @(negedge clk);
        check("hdr_latency", 32'(bus_if.tx_valid), 32'd1);
    endtask

    task automatic do_pkt(input int ndata, input int exp_gid, input int cmd_at);
        int b0;
        int r0[4];
        int t;
        b0 = busy_total;
        for (int i = 0; i < 4; i++) r0[i] = rd_cnt[i];
        start_pkt();
        drain(cmd_at, -1);
        t = 0;
        while (bus_if.busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy_cycles", 32'(busy_total - b0), 32'(4 + 4*ndata + 2*TRL));
        check("sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            check("ch_rd_cnt", 32'(rd_cnt[i] - r0[i]), (i == exp_gid) ? 32'(ndata) : 32'd0);
        if (exp_gid >= 0) check("grant_id", 32'(bus_if.grant_id), 32'(exp_gid));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        int r0;
        rst              = 1'b1;
        bus_if.fifo_cmd  = 1'b0;
        bus_if.word_done = 1'b0;
        bus_if.pkt_len   = 8'd0;
        bus_if.ch_ready  = 4'b0000;

        // Reset state and null header with no channel ready.
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset_tx_valid", 32'(bus_if.tx_valid), 32'd0);
        check("reset_busy",     32'(bus_if.busy),     32'd0);
        check("reset_ch_rd",    32'(bus_if.ch_rd),    32'd0);
        check("reset_tx_data",  32'(bus_if.tx_data),  32'd0);
        check("reset_grant_id", 32'(bus_if.grant_id), 32'd0);
        rst = 1'b0;
        bus_if.pkt_len = 8'd3;
        pdata.delete();
        queue_pkt(-1, 0);
        do_pkt(0, -1, -1);

        // Single ready channel, three words.
        bus_if.ch_ready = 4'b0100;
        pdata = '{16'h0011, 16'h0022, 16'h0033};
        queue_pkt(2, 3);
        do_pkt(3, 2, -1);

        // Round-robin order from reset.
        do_reset();
        bus_if.ch_ready = 4'b1111;
        bus_if.pkt_len  = 8'd1;
        for (int p = 0; p < 5; p++) begin
            pdata = '{16'h0100};
            pdata[0] = pdata[0] + 16'(p * 16'h0111);
            queue_pkt(p % 4, 1);
            do_pkt(1, p % 4, -1);
        end

        // fifo_cmd during SEND is ignored.
        bus_if.pkt_len = 8'd3;
        pdata = '{16'hBEEF, 16'h1234, 16'h0F0F};
        queue_pkt(1, 3);
        do_pkt(3, 1, 2);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.tx_valid || bus_if.busy) extra++;
        end
        check("no_second_hdr", 32'(extra), 32'd0);

        // Reset mid-packet, then the pointer restarts at ch0.
        do_reset();
        bus_if.ch_ready = 4'b0101;
        bus_if.pkt_len  = 8'd4;
        pdata = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        queue_pkt(0, 4);
        r0 = rd_cnt[0];
        start_pkt();
        drain(-1, 2);
        for (int i = 0; i < 4; i++) fifo_q[i].delete();
        repeat (5) @(negedge clk);
        check("rst_rd_stop", 32'(rd_cnt[0] - r0), 32'd2);
        check("rst_idle_busy", 32'(bus_if.busy), 32'd0);
        bus_if.pkt_len = 8'd1;
        pdata = '{16'h0505};
        queue_pkt(0, 1);
        do_pkt(1, 0, -1);

`ifdef SPI_ARB_TRAILER_EN
        do_reset();
        bus_if.ch_ready = 4'b0001;
        bus_if.pkt_len  = 8'd2;
        pdata = '{16'h0003, 16'h0005};
        queue_pkt(0, 2);
        do_pkt(2, 0, -1);
        bus_if.pkt_len = 8'd0;
        pdata.delete();
        queue_pkt(0, 0);
        do_pkt(0, 0, -1);
`endif

        check("rd_single_cycle", 32'(rd_multi), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
